button_pulser: RTL and testbench

- Synchronous front end for the clock's user buttons (enable, sec, min, hour).
- Sits directly upstream of the time counters and the run/stop toggle.
- Per channel: synchronises, debounces and edge-detects the raw pin, then emits single-cycle pulses on press, release and hold auto-repeat, all in the `clk` domain.
- Replaces the separate slow-clock debouncers and the XOR-gated counter clocks with clock-enable pulses.

---
 rtl/button_pulser_pkg.sv | 21 ++
 rtl/button_chan.sv | 144 ++++++++++++++
 rtl/button_pulser.sv | 38 +++
 tb/tb_button_pulser.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pulser_pkg.sv
// Shared definitions for the button front end: hold-FSM encoding,
// default 50 MHz timing constants and a counter-width helper.
package button_pulser_pkg;

    typedef enum logic [1:0] {
        HOLD_IDLE   = 2'd0,
        HOLD_HELD   = 2'd1,
        HOLD_REPEAT = 2'd2
    } hold_state_e;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DBC_10MS     = CLK_HZ / 100;
    localparam int HOLD_500MS   = CLK_HZ / 2;
    localparam int REPEAT_100MS = CLK_HZ / 10;

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_chan.sv
// One button channel: two-flop synchroniser, debounce counter, registered
// edge pulses and a hold/auto-repeat FSM producing step enables.
module button_chan
    import button_pulser_pkg::*;
#(
    parameter int DBC_CYCLES    = DBC_10MS,
    parameter int HOLD_CYCLES   = HOLD_500MS,
    parameter int REPEAT_CYCLES = REPEAT_100MS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_rel,
    output logic btn_step,
    output logic btn_long
);

    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DW   = cnt_width(DBC_CYCLES);
    localparam int HW   = cnt_width(HMAX);

    localparam logic [DW-1:0] DBC_LAST  = DW'(DBC_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    if (DBC_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("button_chan: illegal timing parameters");
    end

    logic          s1_q, s2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          level_q;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          step_q, step_d;
    logic          long_q, long_d;
    hold_state_e   state_q, state_d;
    logic [HW-1:0] htim_q, htim_d;

    logic rise, fall;

    // deb_q is the accepted level; level_q is its registered copy, so every
    // output (level, pulses, step, long) moves on the same edge.
    assign rise = deb_q & ~level_q;
    assign fall = ~deb_q & level_q;

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        if (s2_q != deb_q) begin
            if (dcnt_q == DBC_LAST) begin
                deb_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        press_d = rise;
        rel_d   = fall;
        state_d = state_q;
        htim_d  = htim_q;
        step_d  = 1'b0;
        long_d  = long_q;
        // A release wins over a coinciding timer expiry: no step that cycle.
        if (fall) begin
            state_d = HOLD_IDLE;
            htim_d  = '0;
            long_d  = 1'b0;
        end else begin
            case (state_q)
                HOLD_IDLE: begin
                    if (rise) begin
                        state_d = HOLD_HELD;
                        htim_d  = '0;
                        step_d  = 1'b1;
                    end
                end
                HOLD_HELD: begin
                    if (htim_q == HOLD_LAST) begin
                        state_d = HOLD_REPEAT;
                        htim_d  = '0;
                        step_d  = 1'b1;
                        long_d  = 1'b1;
                    end else begin
                        htim_d = htim_q + 1'b1;
                    end
                end
                HOLD_REPEAT: begin
                    if (htim_q == REP_LAST) begin
                        htim_d = '0;
                        step_d = 1'b1;
                    end else begin
                        htim_d = htim_q + 1'b1;
                    end
                end
                default: begin
                    state_d = HOLD_IDLE;
                    htim_d  = '0;
                    long_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 1'b0;
            dcnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            step_q  <= 1'b0;
            long_q  <= 1'b0;
            state_q <= HOLD_IDLE;
            htim_q  <= '0;
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            level_q <= deb_q;
            press_q <= press_d;
            rel_q   <= rel_d;
            step_q  <= step_d;
            long_q  <= long_d;
            state_q <= state_d;
            htim_q  <= htim_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign btn_rel   = rel_q;
    assign btn_step  = step_q;
    assign btn_long  = long_q;

endmodule

// File: rtl/button_pulser.sv
// Front end for the user buttons: N_BTN independent channels, each turning a
// raw pin into debounced level, press/release pulses and step enables.
module button_pulser
    import button_pulser_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int DBC_CYCLES    = DBC_10MS,
    parameter int HOLD_CYCLES   = HOLD_500MS,
    parameter int REPEAT_CYCLES = REPEAT_100MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_rel,
    output logic [N_BTN-1:0] btn_step,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        button_chan #(
            .DBC_CYCLES    (DBC_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (btn_in[gi]),
            .btn_level (btn_level[gi]),
            .btn_press (btn_press[gi]),
            .btn_rel   (btn_rel[gi]),
            .btn_step  (btn_step[gi]),
            .btn_long  (btn_long[gi])
        );
    end

endmodule

// File: tb/tb_button_pulser.sv
// Directed bench for button_pulser: expected pulses are queued with their
// cycle numbers as stimulus is driven and matched as the DUT emits them.
module tb_button_pulser;

    localparam int N   = 4;
    localparam int DBC = 4;
    localparam int HLD = 20;
    localparam int REP = 8;
    localparam int LAT = DBC + 3;  // drive at negedge -> outputs change this many edges later

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level, btn_press, btn_rel, btn_step, btn_long;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int cyc;
        int ch;
        int kind;  // 0 press, 1 rel, 2 step
    } ev_t;
    ev_t sb[$];

    button_pulser #(
        .N_BTN         (N),
        .DBC_CYCLES    (DBC),
        .HOLD_CYCLES   (HLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_rel   (btn_rel),
        .btn_step  (btn_step),
        .btn_long  (btn_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0:       return "press";
            1:       return "rel";
            default: return "step";
        endcase
    endfunction

    function automatic logic pulse_bit(input int ch, input int k);
        case (k)
            0:       return btn_press[ch];
            1:       return btn_rel[ch];
            default: return btn_step[ch];
        endcase
    endfunction

    task automatic push(input int c, input int ch, input int k);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = k;
        sb.push_back(e);
    endtask

    // Press accepted at cycle p, debounced release at cycle f: step at p and
    // at p+HLD, p+HLD+REP, ... strictly before f.
    task automatic expect_hold(input int ch, input int p, input int f);
        int t;
        push(p, ch, 0);
        push(p, ch, 2);
        t = p + HLD;
        while (t < f) begin
            push(t, ch, 2);
            t += REP;
        end
        push(f, ch, 1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int t, p, f, c, p0, p3, idx;
        logic bitv;
        rst    = 1'b1;
        btn_in = '0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    for (int ch = 0; ch < N; ch++) begin
                        for (int k = 0; k < 3; k++) begin
                            bitv = pulse_bit(ch, k);
                            if (bitv) begin
                                idx = -1;
                                for (int i = 0; i < sb.size(); i++)
                                    if (sb[i].cyc == cyc && sb[i].ch == ch && sb[i].kind == k) idx = i;
                                check($sformatf("%s%0d_expected", kname(k), ch),
                                      32'(idx >= 0), 32'd1);
                                if (idx >= 0) sb.delete(idx);
                            end
                        end
                    end
                    for (int i = sb.size() - 1; i >= 0; i--) begin
                        if (sb[i].cyc <= cyc) begin
                            check($sformatf("%s%0d_missed_at_%0d", kname(sb[i].kind), sb[i].ch, sb[i].cyc),
                                  32'(pulse_bit(sb[i].ch, sb[i].kind)), 32'd1);
                            sb.delete(i);
                        end
                    end
                end
            end
        join_none

        // Reset state
        wait_cyc(3);
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_press", 32'(btn_press), 32'd0);
        check("reset_rel",   32'(btn_rel),   32'd0);
        check("reset_step",  32'(btn_step),  32'd0);
        check("reset_long",  32'(btn_long),  32'd0);
        rst = 1'b0;

        // Clean press on channel 1, held 10 cycles
        wait_cyc(5);
        t = cyc;
        btn_in[1] = 1'b1;
        p = t + LAT;
        f = t + 10 + LAT;
        expect_hold(1, p, f);
        wait_cyc(p - 1);
        check("clean_level_before", 32'(btn_level[1]), 32'd0);
        wait_cyc(p);
        check("clean_level_at", 32'(btn_level[1]), 32'd1);
        wait_cyc(t + 10);
        btn_in[1] = 1'b0;
        wait_cyc(t + 12);
        check("clean_no_long", 32'(btn_long[1]), 32'd0);
        wait_cyc(f);
        check("clean_level_released", 32'(btn_level[1]), 32'd0);

        // Glitch rejection on channel 0, then a just-long-enough pulse
        wait_cyc(f + 3);
        t = cyc;
        btn_in[0] = 1'b1;
        wait_cyc(t + 3);
        btn_in[0] = 1'b0;
        wait_cyc(t + 12);
        check("glitch_level", 32'(btn_level[0]), 32'd0);
        t = cyc;
        btn_in[0] = 1'b1;
        expect_hold(0, t + LAT, t + 4 + LAT);
        wait_cyc(t + 4);
        btn_in[0] = 1'b0;
        wait_cyc(t + LAT);
        check("min_pulse_level", 32'(btn_level[0]), 32'd1);
        wait_cyc(t + 14);

        // Auto-repeat on channel 2, held 60 cycles past acceptance
        t = cyc;
        btn_in[2] = 1'b1;
        p = t + LAT;
        f = p + 60 + LAT;
        expect_hold(2, p, f);
        wait_cyc(p + HLD - 1);
        check("repeat_long_before", 32'(btn_long[2]), 32'd0);
        wait_cyc(p + HLD);
        check("repeat_long_first", 32'(btn_long[2]), 32'd1);
        wait_cyc(p + 60);
        btn_in[2] = 1'b0;
        wait_cyc(f - 1);
        check("repeat_long_held", 32'(btn_long[2]), 32'd1);
        wait_cyc(f);
        check("repeat_long_cleared", 32'(btn_long[2]), 32'd0);
        check("repeat_level_cleared", 32'(btn_level[2]), 32'd0);

        // Release whose debounced fall coincides with a repeat expiry
        wait_cyc(f + 5);
        t = cyc;
        btn_in[2] = 1'b1;
        p = t + LAT;
        f = p + HLD + 2 * REP;
        expect_hold(2, p, f);
        wait_cyc(f - LAT);
        btn_in[2] = 1'b0;
        wait_cyc(f);
        check("expiry_long_cleared", 32'(btn_long[2]), 32'd0);
        check("expiry_step_suppressed", 32'(btn_step[2]), 32'd0);
        // FSM back in IDLE: a short press gives exactly one step
        wait_cyc(f + 3);
        t = cyc;
        btn_in[2] = 1'b1;
        expect_hold(2, t + LAT, t + 5 + LAT);
        wait_cyc(t + 5);
        btn_in[2] = 1'b0;
        wait_cyc(t + 15);

        // Reset while channel 3 is auto-repeating
        t = cyc;
        btn_in[3] = 1'b1;
        p = t + LAT;
        push(p, 3, 0);
        push(p, 3, 2);
        push(p + HLD, 3, 2);
        wait_cyc(p + HLD + 5);
        check("pre_reset_long", 32'(btn_long[3]), 32'd1);
        c = cyc;
        rst = 1'b1;
        wait_cyc(c + 1);
        check("midreset_level", 32'(btn_level), 32'd0);
        check("midreset_long",  32'(btn_long),  32'd0);
        check("midreset_step",  32'(btn_step),  32'd0);
        wait_cyc(c + 2);
        rst = 1'b0;
        p = c + 2 + LAT;
        f = p + 22 + LAT;
        expect_hold(3, p, f);
        wait_cyc(p - 1);
        check("postreset_level_before", 32'(btn_level[3]), 32'd0);
        wait_cyc(p + HLD);
        check("postreset_long", 32'(btn_long[3]), 32'd1);
        wait_cyc(p + 22);
        btn_in[3] = 1'b0;
        wait_cyc(f + 5);

        // Independence: channels 0 and 3 pressed two cycles apart
        t = cyc;
        btn_in[0] = 1'b1;
        p0 = t + LAT;
        p3 = t + 2 + LAT;
        expect_hold(0, p0, p0 + 25 + LAT);
        expect_hold(3, p3, p3 + 30 + LAT);
        wait_cyc(t + 2);
        btn_in[3] = 1'b1;
        wait_cyc(p0 + HLD);
        check("indep_long0", 32'(btn_long[0]), 32'd1);
        check("indep_long3_not_yet", 32'(btn_long[3]), 32'd0);
        wait_cyc(p3 + HLD);
        check("indep_long3", 32'(btn_long[3]), 32'd1);
        wait_cyc(p0 + 25);
        btn_in[0] = 1'b0;
        wait_cyc(p3 + 30);
        btn_in[3] = 1'b0;
        check("indep_long0_cleared", 32'(btn_long[0]), 32'd0);
        check("indep_long3_still", 32'(btn_long[3]), 32'd1);
        wait_cyc(p3 + 30 + LAT + 5);

        // Anything still queued never appeared
        while (sb.size() > 0) begin
            check($sformatf("%s%0d_never_seen_%0d", kname(sb[0].kind), sb[0].ch, sb[0].cyc),
                  32'd0, 32'd1);
            void'(sb.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
